// File: rtl/load_store_unit_if.sv
// Bundle of the execute-stage request/response signals and the data-memory bus
// seen by the load/store unit.
//   master : the LSU side (accepts ops, returns responses, drives dmem requests).
//   slave  : the environment side (execute stage plus data memory).
interface load_store_unit_if;
  // Execute-stage request
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  // Completion
  logic        resp_valid;
  logic [31:0] load_data;
  logic [4:0]  resp_rd;
  logic        exception;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  // Data-memory bus
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    input  req_valid, mem_read, mem_write, funct3, addr, store_data, rd,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, resp_valid, load_data, resp_rd, exception, exc_cause, exc_addr,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
  );

  modport slave (
    output req_valid, mem_read, mem_write, funct3, addr, store_data, rd,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, resp_valid, load_data, resp_rd, exception, exc_cause, exc_addr,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one memory op at a time from execute, checks
// legality/alignment, issues a single dmem bus transaction with lane formatting,
// extracts/extends load data and returns a one-cycle completion pulse. Bus waits
// are bounded by TIMEOUT_CYCLES (counted across REQ and WAIT).
// Ports:
//   clk   : clock, rising edge.
//   reset : synchronous, active-low.
//   lsu   : request/response and dmem bus signals (master view). All outputs registered.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master lsu
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic [15:0] CntLimit     = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  CauseMisalig = 2'd1;
  localparam logic [1:0]  CauseIllegal = 2'd2;
  localparam logic [1:0]  CauseTimeout = 2'd3;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        exception_q, exception_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;

  logic        illegal, misaligned, timeout;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode of the op presented at the request port.
  always_comb begin
    illegal = (lsu.mem_read && lsu.mem_write) ||
              (lsu.mem_read && !(lsu.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              (lsu.mem_write && !(lsu.funct3 inside {3'd0, 3'd1, 3'd2}));
    // funct3[1:0] encodes access size for every legal load/store.
    misaligned = ((lsu.funct3[1:0] == 2'd1) && lsu.addr[0]) ||
                 ((lsu.funct3[1:0] == 2'd2) && (lsu.addr[1:0] != 2'd0));
    unique case (lsu.funct3[1:0])
      2'd0: begin
        st_strb  = 4'b0001 << lsu.addr[1:0];
        st_wdata = {4{lsu.store_data[7:0]}};
      end
      2'd1: begin
        st_strb  = 4'b0011 << {lsu.addr[1], 1'b0};
        st_wdata = {2{lsu.store_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = lsu.store_data;
      end
    endcase
  end

  // Load extraction uses the captured op, since the data arrives later.
  always_comb begin
    ld_byte = lsu.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? lsu.dmem_rdata[31:16] : lsu.dmem_rdata[15:0];
    unique case (funct3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = lsu.dmem_rdata;
    endcase
  end

  assign timeout = (cnt_q == CntLimit);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    resp_valid_d = 1'b0;
    load_data_d  = '0;
    resp_rd_d    = '0;
    exception_d  = 1'b0;
    exc_cause_d  = '0;
    exc_addr_d   = '0;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;

    unique case (state_q)
      StIdle: begin
        if (lsu.req_valid) begin
          is_load_d = lsu.mem_read;
          funct3_d  = lsu.funct3;
          addr_d    = lsu.addr;
          rd_d      = lsu.rd;
          if (!lsu.mem_read && !lsu.mem_write) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rd_d    = lsu.rd;
          end else if (illegal || misaligned) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rd_d    = lsu.rd;
            exception_d  = 1'b1;
            exc_cause_d  = illegal ? CauseIllegal : CauseMisalig;
            exc_addr_d   = lsu.addr;
          end else begin
            state_d      = StReq;
            cnt_d        = '0;
            dmem_req_d   = 1'b1;
            dmem_we_d    = lsu.mem_write;
            dmem_addr_d  = {lsu.addr[31:2], 2'b00};
            dmem_wdata_d = lsu.mem_write ? st_wdata : '0;
            dmem_wstrb_d = lsu.mem_write ? st_strb : '0;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        if (lsu.dmem_gnt || timeout) begin
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_addr_d  = '0;
          dmem_wdata_d = '0;
          dmem_wstrb_d = '0;
        end
        // Grant wins over a coincident timeout.
        if (lsu.dmem_gnt) begin
          if (is_load_q) begin
            state_d = StWait;
          end else begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rd_d    = rd_q;
          end
        end else if (timeout) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          exception_d  = 1'b1;
          exc_cause_d  = CauseTimeout;
          exc_addr_d   = addr_q;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        if (lsu.dmem_rvalid) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          load_data_d  = ld_data;
        end else if (timeout) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          exception_d  = 1'b1;
          exc_cause_d  = CauseTimeout;
          exc_addr_d   = addr_q;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      is_load_q    <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      rd_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      load_data_q  <= '0;
      resp_rd_q    <= '0;
      exception_q  <= 1'b0;
      exc_cause_q  <= '0;
      exc_addr_q   <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      load_data_q  <= load_data_d;
      resp_rd_q    <= resp_rd_d;
      exception_q  <= exception_d;
      exc_cause_q  <= exc_cause_d;
      exc_addr_q   <= exc_addr_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
    end
  end

  assign lsu.req_ready  = req_ready_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.load_data  = load_data_q;
  assign lsu.resp_rd    = resp_rd_q;
  assign lsu.exception  = exception_q;
  assign lsu.exc_cause  = exc_cause_q;
  assign lsu.exc_addr   = exc_addr_q;
  assign lsu.dmem_req   = dmem_req_q;
  assign lsu.dmem_we    = dmem_we_q;
  assign lsu.dmem_addr  = dmem_addr_q;
  assign lsu.dmem_wdata = dmem_wdata_q;
  assign lsu.dmem_wstrb = dmem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4). Each op pushes its
// expected completion onto a scoreboard queue; a negedge monitor pops and compares.
module tb_load_store_unit;

  localparam int unsigned Timeout = 4;
  localparam int          Never   = 99;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk  (clk),
    .reset(reset),
    .lsu  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  cause;
    logic [31:0] eaddr;
    int          due;
  } resp_t;

  resp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    resp_t e;
    if (mon_en) begin
      if (bus.resp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_resp", 64'(bus.resp_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq({e.name, ".resp_rd"}, 64'(bus.resp_rd), 64'(e.rd));
          check_eq({e.name, ".load_data"}, 64'(bus.load_data), 64'(e.data));
          check_eq({e.name, ".exception"}, 64'(bus.exception), 64'(e.exc));
          check_eq({e.name, ".exc_cause"}, 64'(bus.exc_cause), 64'(e.cause));
          check_eq({e.name, ".exc_addr"}, 64'(bus.exc_addr), 64'(e.eaddr));
          check_eq({e.name, ".latency_cycle"}, 64'(cyc), 64'(e.due));
        end
      end else begin
        check_eq("exc_fields_idle", 64'({bus.exception, bus.exc_cause, bus.exc_addr}), 64'd0);
      end
    end
  end

  // One op end to end. gw = REQ cycles before grant, rw = WAIT cycles before rvalid
  // (Never = withhold). x_cause = 0 for a clean completion.
  task automatic run_op(input string name, input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tag,
                        input int gw, input int rw, input logic [31:0] rdata,
                        input logic [3:0] x_strb, input logic [31:0] x_wdata,
                        input logic [31:0] x_ld, input logic [1:0] x_cause);
    resp_t e;
    bit    bus_op;
    bit    granted;
    int    lat;
    int    req_cycles;
    int    k;
    bus_op  = (r || w) && (x_cause == 2'd0 || x_cause == 2'd3);
    granted = bus_op && (gw < int'(Timeout));
    if (!bus_op)          lat = 1;
    else if (!granted)    lat = int'(Timeout) + 1;
    else if (w)           lat = 2 + gw;
    else if (rw != Never) lat = 3 + gw + rw;
    else                  lat = int'(Timeout) + 1;

    @(negedge clk);
    check_eq({name, ".req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.mem_read   = r;
    bus.mem_write  = w;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = wd;
    bus.rd         = tag;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    e.name  = name;
    e.rd    = tag;
    e.data  = x_ld;
    e.exc   = (x_cause != 2'd0);
    e.cause = x_cause;
    e.eaddr = (x_cause != 2'd0) ? a : 32'd0;
    e.due   = cyc + lat - 1;
    sb_q.push_back(e);

    if (bus_op) begin
      req_cycles = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (bus.dmem_req !== 1'b1) break;
        req_cycles++;
        check_eq({name, ".dmem_addr"}, 64'(bus.dmem_addr), 64'(a & 32'hFFFF_FFFC));
        check_eq({name, ".dmem_we"}, 64'(bus.dmem_we), 64'(w));
        check_eq({name, ".dmem_wstrb"}, 64'(bus.dmem_wstrb), 64'(x_strb));
        if (w) check_eq({name, ".dmem_wdata"}, 64'(bus.dmem_wdata), 64'(x_wdata));
        if (i == gw) begin
          bus.dmem_gnt    = 1'b1;
          bus.dmem_rvalid = 1'b0;
          @(posedge clk);
          #1;
          bus.dmem_gnt = 1'b0;
          break;
        end else if (r) begin
          // Stray read data while not yet granted must be ignored.
          bus.dmem_rvalid = 1'b1;
          bus.dmem_rdata  = 32'hBAD0_BAD0;
        end
      end
      bus.dmem_rvalid = 1'b0;
      check_eq({name, ".req_cycles"}, 64'(req_cycles),
               64'(granted ? gw + 1 : int'(Timeout)));
      if (granted && r && rw != Never) begin
        repeat (rw) begin
          @(posedge clk);
          #1;
        end
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        @(posedge clk);
        #1;
        bus.dmem_rvalid = 1'b0;
      end
    end else begin
      @(negedge clk);
      check_eq({name, ".no_dmem_req"}, 64'(bus.dmem_req), 64'd0);
    end

    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (sb_q.size() != 0 && k < 30);
    if (sb_q.size() != 0) begin
      check_eq({name, ".resp_missing"}, 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.funct3      = '0;
    bus.addr        = '0;
    bus.store_data  = '0;
    bus.rd          = '0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = '0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst.req_ready", 64'(bus.req_ready), 64'd1);
    check_eq("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rst.dmem_req", 64'(bus.dmem_req), 64'd0);
    check_eq("rst.dmem_wstrb", 64'(bus.dmem_wstrb), 64'd0);
    check_eq("rst.load_data", 64'(bus.load_data), 64'd0);
    check_eq("rst.exception", 64'(bus.exception), 64'd0);
    mon_en = 1'b1;

    //     name          r     w     f3    addr          wdata          rd  gw     rw     rdata          strb     wdata          load_data      cause
    run_op("sw_100",     1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1,  0,     0,     32'h0,         4'b1111, 32'hDEAD_BEEF, 32'h0,         2'd0);
    run_op("sb_103",     1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 2,  0,     0,     32'h0,         4'b1000, 32'hA5A5_A5A5, 32'h0,         2'd0);
    run_op("sb_001",     1'b0, 1'b1, 3'd0, 32'h0000_0001, 32'h1234_5677, 3,  1,     0,     32'h0,         4'b0010, 32'h7777_7777, 32'h0,         2'd0);
    run_op("sh_102",     1'b0, 1'b1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 4,  2,     0,     32'h0,         4'b1100, 32'hABCD_ABCD, 32'h0,         2'd0);
    run_op("sh_100",     1'b0, 1'b1, 3'd1, 32'h0000_0100, 32'hFFFF_8001, 5,  0,     0,     32'h0,         4'b0011, 32'h8001_8001, 32'h0,         2'd0);
    run_op("lh_202",     1'b1, 1'b0, 3'd1, 32'h0000_0202, 32'h0,         6,  0,     0,     32'h80FF_1234, 4'b0000, 32'h0,         32'hFFFF_80FF, 2'd0);
    run_op("lhu_202",    1'b1, 1'b0, 3'd5, 32'h0000_0202, 32'h0,         7,  0,     0,     32'h80FF_1234, 4'b0000, 32'h0,         32'h0000_80FF, 2'd0);
    run_op("lbu_203",    1'b1, 1'b0, 3'd4, 32'h0000_0203, 32'h0,         8,  0,     0,     32'h80FF_1234, 4'b0000, 32'h0,         32'h0000_0080, 2'd0);
    run_op("lb_203",     1'b1, 1'b0, 3'd0, 32'h0000_0203, 32'h0,         9,  1,     0,     32'h80FF_1234, 4'b0000, 32'h0,         32'hFFFF_FF80, 2'd0);
    run_op("lb_201",     1'b1, 1'b0, 3'd0, 32'h0000_0201, 32'h0,         10, 0,     2,     32'h80FF_1234, 4'b0000, 32'h0,         32'h0000_0012, 2'd0);
    run_op("lh_200",     1'b1, 1'b0, 3'd1, 32'h0000_0200, 32'h0,         11, 0,     0,     32'h0001_7FFF, 4'b0000, 32'h0,         32'h0000_7FFF, 2'd0);
    run_op("lw_204",     1'b1, 1'b0, 3'd2, 32'h0000_0204, 32'h0,         12, 0,     0,     32'h80FF_1234, 4'b0000, 32'h0,         32'h80FF_1234, 2'd0);
    run_op("lw_mis",     1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0,         13, 0,     0,     32'h0,         4'b0000, 32'h0,         32'h0,         2'd1);
    run_op("ld_f3_3",    1'b1, 1'b0, 3'd3, 32'h0000_0200, 32'h0,         14, 0,     0,     32'h0,         4'b0000, 32'h0,         32'h0,         2'd2);
    run_op("sh_mis",     1'b0, 1'b1, 3'd1, 32'h0000_0101, 32'h0,         15, 0,     0,     32'h0,         4'b0000, 32'h0,         32'h0,         2'd1);
    run_op("st_f3_4",    1'b0, 1'b1, 3'd4, 32'h0000_0101, 32'h0,         16, 0,     0,     32'h0,         4'b0000, 32'h0,         32'h0,         2'd2);
    run_op("rd_and_wr",  1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h0,         17, 0,     0,     32'h0,         4'b0000, 32'h0,         32'h0,         2'd2);
    run_op("noop",       1'b0, 1'b0, 3'd2, 32'h0000_0055, 32'h0,         18, 0,     0,     32'h0,         4'b0000, 32'h0,         32'h0,         2'd0);
    run_op("sw_to_req",  1'b0, 1'b1, 3'd2, 32'h0000_0300, 32'h1111_2222, 19, Never, 0,     32'h0,         4'b1111, 32'h1111_2222, 32'h0,         2'd3);
    run_op("lw_to_req",  1'b1, 1'b0, 3'd2, 32'h0000_0304, 32'h0,         20, Never, 0,     32'h0,         4'b0000, 32'h0,         32'h0,         2'd3);
    run_op("lw_to_wait", 1'b1, 1'b0, 3'd2, 32'h0000_0308, 32'h0,         21, 0,     Never, 32'h0,         4'b0000, 32'h0,         32'h0,         2'd3);
    run_op("lw_rv_edge", 1'b1, 1'b0, 3'd2, 32'h0000_030C, 32'h0,         22, 1,     1,     32'hCAFE_F00D, 4'b0000, 32'h0,         32'hCAFE_F00D, 2'd0);
    run_op("sw_gnt_edge",1'b0, 1'b1, 3'd2, 32'h0000_0310, 32'h0102_0304, 23, 3,     0,     32'h0,         4'b1111, 32'h0102_0304, 32'h0,         2'd0);

    // Reset while a load sits in WAIT: op is dropped, late rvalid ignored.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_read  = 1'b1;
    bus.funct3    = 3'd2;
    bus.addr      = 32'h0000_0400;
    bus.rd        = 5'd24;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_read  = 1'b0;
    @(negedge clk);
    check_eq("abort.dmem_req_before", 64'(bus.dmem_req), 64'd1);
    bus.dmem_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.dmem_gnt = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset           = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1111_1111;
    @(negedge clk);
    check_eq("abort.dmem_req_after", 64'(bus.dmem_req), 64'd0);
    check_eq("abort.req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.dmem_rvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("abort.no_resp", 64'(bus.resp_valid), 64'd0);
    end
    check_eq("abort.req_ready_later", 64'(bus.req_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, which is the bus wait limit in cycles counted in REQ+WAIT (range 1..65535).
REQ-002 The block SHALL have the following ports. Clock and reset come first. All outputs are registered.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  LSU can accept an op.
- mem_read  in  1  op is a load.
- mem_write  in  1  op is a store.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  effective address (ALU result).
- store_data  in  32  rs2 value.
- rd  in  5  destination register tag.
- resp_valid  out  1  one-cycle completion pulse.
- load_data  out  32  aligned, extended load result.
- resp_rd  out  5  rd of the completed op.
- exception  out  1  completed op faulted.
- exc_cause  out  2  1 = misaligned, 2 = illegal, 3 = bus timeout.
- exc_addr  out  32  faulting addr.
- dmem_req  out  1  bus request; held until granted.
- dmem_we  out  1  bus write.
- dmem_addr  out  32  word address, with {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables; 0 on reads.
- dmem_gnt  in  1  bus accepted the request this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read word.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT and RESP. req_ready SHALL be 1 only in IDLE.
REQ-004 An op SHALL be accepted on a rising edge where req_valid=1 and req_ready=1. At acceptance the block SHALL capture mem_read, mem_write, funct3, addr, store_data and rd.
REQ-005 Legal funct3 values SHALL be as follows; any other value is illegal (cause 2).
- Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- Stores: 0 SB, 1 SH, 2 SW.
REQ-006 mem_read=1 together with mem_write=1 SHALL be illegal (cause 2).
REQ-007 The following SHALL be misaligned (cause 1). Illegal SHALL take priority over misaligned.
- H with addr[0]=1.
- W with addr[1:0]!=0.
REQ-008 A faulting op SHALL go IDLE->RESP and SHALL never raise dmem_req. In RESP it SHALL produce resp_valid=1, exception=1, exc_cause and exc_addr=addr, with load_data=0.
REQ-009 An op with mem_read=0 and mem_write=0 (no-op) SHALL go IDLE->RESP and SHALL produce resp_valid=1 with exception=0 and load_data=0.
REQ-010 A legal op SHALL go IDLE->REQ. dmem_req=1 SHALL be asserted and all dmem_* outputs SHALL be held stable until the cycle dmem_gnt=1.
REQ-011 On grant, a store SHALL go to RESP and a load SHALL go to WAIT. dmem_rvalid SHALL be ignored outside WAIT.
REQ-012 In WAIT, dmem_rvalid=1 SHALL capture the extracted data and move to RESP.
REQ-013 Store lanes SHALL be formed as follows.
- SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{byte}}.
- SH: wstrb = 4'b0011<<{addr[1],1'b0}, wdata = {2{half}}.
- SW: wstrb = 4'b1111, wdata = store_data.
REQ-014 Load extraction SHALL select the byte at addr[1:0] or the half at addr[1]. LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-015 RESP SHALL last exactly one cycle with resp_valid=1 and resp_rd=rd, then return to IDLE. There SHALL be no response backpressure.
REQ-016 Minimum latency, measuring acceptance as edge N, SHALL be:
- Store: resp_valid in cycle N+2.
- Load: resp_valid in cycle N+3.
- Fault or no-op: resp_valid in cycle N+1.
REQ-017 A 16-bit wait counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-018 When the wait counter reaches TIMEOUT_CYCLES with no grant or rvalid, the block SHALL drop dmem_req and go to RESP with exception=1, exc_cause=3, exc_addr=addr.
REQ-019 If dmem_gnt or dmem_rvalid arrives in the same cycle the counter reaches its limit, the grant or rvalid SHALL win.
REQ-020 exception, exc_cause and exc_addr SHALL be valid only while resp_valid=1. They SHALL be 0 otherwise.

Reset
REQ-021 While reset=0 at a clock edge, the block SHALL set the following; the initial outputs apply from the next cycle onward.
- FSM to IDLE.
- Wait counter to 0.
- All outputs to 0, except req_ready=1 in the first cycle after reset releases.
REQ-022 A reset in REQ or WAIT SHALL abort the op with no resp_valid. dmem_req SHALL be 0 from the cycle after the reset edge. A late dmem_rvalid SHALL be ignored.

Verification
REQ-023 SW addr=0x100 data=0xDEADBEEF, gnt in the first REQ cycle -> dmem_wstrb=1111, dmem_addr=0x100; resp_valid at N+2 with exception=0.
REQ-024 SB addr=0x103 data=0x000000A5 -> dmem_wstrb=1000, dmem_wdata=0xA5A5A5A5.
REQ-025 Loads at addr=0x202 with rdata=0x80FF1234 and rvalid one cycle after grant:
- LH -> load_data=0xFFFF80FF.
- LHU -> load_data=0x000080FF.
- LBU at 0x203 -> load_data=0x00000080.
- resp_valid at N+3.
REQ-026 LW addr=0x101 -> no dmem_req; resp_valid at N+1 with exception=1, exc_cause=1, exc_addr=0x101. Load funct3=3 -> exc_cause=2.
REQ-027 TIMEOUT_CYCLES=4 with gnt held 0 -> dmem_req high for 4 cycles, then resp_valid with exc_cause=3.
REQ-028 Reset asserted in WAIT, then rvalid=1 -> no resp_valid; req_ready=1 after release.
